// File: rtl/fft8_pkg.sv
// Shared constants, twiddle table, state encoding and helpers for the 8-point
// radix-2 DIT FFT sequencer.
package fft8_pkg;

  localparam int unsigned N     = 8;
  localparam int unsigned LOG2N = 3;

  localparam logic [31:0] Q_ONE     = 32'h0001_0000;
  localparam logic [31:0] Q_RSQRT2  = 32'h0000_B504;
  localparam logic [31:0] Q_NRSQRT2 = 32'hFFFF_4AFC;
  localparam logic [31:0] Q_NONE    = 32'hFFFF_0000;

  // Forward twiddles W^k = exp(-j*2*pi*k/8), index k in [0] .. [3]
  localparam logic [3:0][31:0] TW_RE = {Q_NRSQRT2, 32'h0, Q_RSQRT2, Q_ONE};
  localparam logic [3:0][31:0] TW_IM = {Q_NRSQRT2, Q_NONE, Q_NRSQRT2, 32'h0};

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StIssue = 2'd1;
  localparam state_t StDrain = 2'd2;
  localparam state_t StDone  = 2'd3;

  function automatic logic [2:0] bitrev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/fft8_bfly_sched_if.sv
// Bus between the FFT sequencer and the shared external butterfly unit.
interface fft8_bfly_sched_if #(
  parameter int unsigned DW = 32
) ();

  logic          bf_valid;
  logic [DW-1:0] bf_ar;
  logic [DW-1:0] bf_ai;
  logic [DW-1:0] bf_br;
  logic [DW-1:0] bf_bi;
  logic [DW-1:0] bf_wr;
  logic [DW-1:0] bf_wi;
  logic [DW-1:0] bf_z1r;
  logic [DW-1:0] bf_z1i;
  logic [DW-1:0] bf_z2r;
  logic [DW-1:0] bf_z2i;

  modport master (
    output bf_valid, bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi,
    input  bf_z1r, bf_z1i, bf_z2r, bf_z2i
  );

  modport slave (
    input  bf_valid, bf_ar, bf_ai, bf_br, bf_bi, bf_wr, bf_wi,
    output bf_z1r, bf_z1i, bf_z2r, bf_z2i
  );

endinterface

// File: rtl/fft8_tw_rom.sv
// Combinational twiddle lookup; inv conjugates the twiddle for the IFFT.
module fft8_tw_rom
  import fft8_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [1:0]    k,
  input  logic          inv,
  output logic [DW-1:0] wr,
  output logic [DW-1:0] wi
);

  logic [31:0] im;

  always_comb begin
    im = TW_IM[k];
    if (inv) im = 32'd0 - im;
    wr = DW'(TW_RE[k]);
    wi = DW'(im);
  end

endmodule

// File: rtl/fft8_bfly_sched.sv
// In-place 8-point radix-2 DIT FFT/IFFT sequencer driving one shared butterfly:
// 3 stages x 4 butterflies, results written back after a fixed BF_LAT latency.
module fft8_bfly_sched
  import fft8_pkg::*;
#(
  parameter int unsigned BF_LAT = 1,
  parameter int unsigned DW     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              inv,
  input  logic              ld_we,
  input  logic [2:0]        ld_addr,
  input  logic [DW-1:0]     ld_re,
  input  logic [DW-1:0]     ld_im,
  input  logic [2:0]        rd_addr,
  output logic [DW-1:0]     rd_re,
  output logic [DW-1:0]     rd_im,
  fft8_bfly_sched_if.master bf,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

  state_t          state_q, state_d;
  logic [1:0]      stage_q, stage_d;
  logic [1:0]      bfly_q, bfly_d;
  logic [CntW-1:0] drain_q, drain_d;
  logic            inv_q, inv_d;

  logic [DW-1:0]   ram_re_q [N];
  logic [DW-1:0]   ram_im_q [N];

  logic [BF_LAT-1:0] tag_vld_q;
  logic [2:0]        tag_top_q [BF_LAT];
  logic [2:0]        tag_bot_q [BF_LAT];

  logic          issue;
  logic [2:0]    top, bot;
  logic [1:0]    tw_k;
  logic [DW-1:0] tw_wr, tw_wi;
  logic          wb_vld;
  logic [2:0]    wb_top, wb_bot;

  assign issue  = (state_q == StIssue);
  assign busy   = (state_q == StIssue) || (state_q == StDrain);
  assign done   = (state_q == StDone);
  assign rd_re  = ram_re_q[rd_addr];
  assign rd_im  = ram_im_q[rd_addr];
  assign wb_vld = tag_vld_q[BF_LAT-1];
  assign wb_top = tag_top_q[BF_LAT-1];
  assign wb_bot = tag_bot_q[BF_LAT-1];

  // Operand pair and twiddle exponent for (stage, bfly): span h = 2^stage.
  always_comb begin
    top  = '0;
    bot  = '0;
    tw_k = '0;
    unique case (stage_q)
      2'd0: begin
        top  = {bfly_q, 1'b0};
        bot  = {bfly_q, 1'b1};
        tw_k = 2'd0;
      end
      2'd1: begin
        top  = {bfly_q[1], 1'b0, bfly_q[0]};
        bot  = {bfly_q[1], 1'b1, bfly_q[0]};
        tw_k = {bfly_q[0], 1'b0};
      end
      2'd2: begin
        top  = {1'b0, bfly_q};
        bot  = {1'b1, bfly_q};
        tw_k = bfly_q;
      end
      default: begin
        top  = '0;
        bot  = '0;
        tw_k = '0;
      end
    endcase
  end

  fft8_tw_rom #(
    .DW(DW)
  ) u_tw_rom (
    .k  (tw_k),
    .inv(inv_q),
    .wr (tw_wr),
    .wi (tw_wi)
  );

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    drain_d = drain_q;
    inv_d   = inv_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StIssue;
          inv_d   = inv;
          stage_d = '0;
          bfly_d  = '0;
        end
      end
      StIssue: begin
        bfly_d = bfly_q + 2'd1;
        if (bfly_q == 2'd3) begin
          state_d = StDrain;
          drain_d = '0;
        end
      end
      StDrain: begin
        drain_d = drain_q + CntW'(1);
        // The last write of this stage lands on the edge that leaves DRAIN.
        if (drain_q == CntW'(BF_LAT - 1)) begin
          drain_d = '0;
          if (stage_q == 2'd2) begin
            state_d = StDone;
          end else begin
            state_d = StIssue;
            stage_d = stage_q + 2'd1;
            bfly_d  = '0;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      stage_q <= '0;
      bfly_q  <= '0;
      drain_q <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      drain_q <= drain_d;
      inv_q   <= inv_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int i = 0; i < BF_LAT; i++) begin
        tag_top_q[i] <= '0;
        tag_bot_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= issue;
      tag_top_q[0] <= top;
      tag_bot_q[0] <= bot;
      for (int i = 1; i < BF_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_top_q[i] <= tag_top_q[i-1];
        tag_bot_q[i] <= tag_bot_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bf.bf_valid <= 1'b0;
      bf.bf_ar    <= '0;
      bf.bf_ai    <= '0;
      bf.bf_br    <= '0;
      bf.bf_bi    <= '0;
      bf.bf_wr    <= '0;
      bf.bf_wi    <= '0;
    end else begin
      bf.bf_valid <= issue;
      if (issue) begin
        bf.bf_ar <= ram_re_q[top];
        bf.bf_ai <= ram_im_q[top];
        bf.bf_br <= ram_re_q[bot];
        bf.bf_bi <= ram_im_q[bot];
        bf.bf_wr <= tw_wr;
        bf.bf_wi <= tw_wi;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        ram_re_q[i] <= '0;
        ram_im_q[i] <= '0;
      end
    end else if (wb_vld) begin
      ram_re_q[wb_top] <= bf.bf_z1r;
      ram_im_q[wb_top] <= bf.bf_z1i;
      ram_re_q[wb_bot] <= bf.bf_z2r;
      ram_im_q[wb_bot] <= bf.bf_z2i;
    end else if (ld_we && !busy) begin
      ram_re_q[bitrev3(ld_addr)] <= ld_re;
      ram_im_q[bitrev3(ld_addr)] <= ld_im;
    end
  end

endmodule

// File: tb/tb_fft8_bfly_sched.sv
// Self-checking bench: models the external butterfly and compares the sequencer
// against an array-based reference FFT built from the stage/pair/twiddle rules.
module tb_fft8_bfly_sched;

  localparam int unsigned BF_LAT   = 1;
  localparam int unsigned DW       = 32;
  localparam int          DONE_CYC = 13 + 3 * BF_LAT;

  typedef logic [31:0] vec_t [8];
  typedef struct packed {
    logic [31:0] ar, ai, br, bi, wr, wi;
  } iss_t;

  logic        clk = 1'b0;
  logic        rst, start, inv, ld_we;
  logic [2:0]  ld_addr, rd_addr;
  logic [31:0] ld_re, ld_im, rd_re, rd_im;
  logic        busy, done;

  int n_checks = 0;
  int n_errors = 0;

  iss_t obs_q[$];
  iss_t exp_q[$];

  logic [31:0] tw_re [4] = '{32'h0001_0000, 32'h0000_B504, 32'h0000_0000, 32'hFFFF_4AFC};
  logic [31:0] tw_im [4] = '{32'h0000_0000, 32'hFFFF_4AFC, 32'hFFFF_0000, 32'hFFFF_4AFC};

  fft8_bfly_sched_if #(.DW(DW)) bf_bus ();

  fft8_bfly_sched #(
    .BF_LAT(BF_LAT),
    .DW    (DW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .inv    (inv),
    .ld_we  (ld_we),
    .ld_addr(ld_addr),
    .ld_re  (ld_re),
    .ld_im  (ld_im),
    .rd_addr(rd_addr),
    .rd_re  (rd_re),
    .rd_im  (rd_im),
    .bf     (bf_bus),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] qmul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p[47:16];
  endfunction

  function automatic void bfly_calc(input logic [31:0] ar, ai, br, bi, wr, wi,
                                    output logic [31:0] z1r, z1i, z2r, z2i);
    logic [31:0] tr, ti;
    tr  = qmul(wr, br) - qmul(wi, bi);
    ti  = qmul(wr, bi) + qmul(wi, br);
    z1r = ar + tr;
    z1i = ai + ti;
    z2r = ar - tr;
    z2i = ai - ti;
  endfunction

  function automatic int brev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  function automatic logic [31:0] rnd_q();
    return 32'($urandom_range(0, 32'h001F_FFFF)) - 32'h0010_0000;
  endfunction

  // External butterfly: BF_LAT cycles from the registered issue to the result.
  logic [31:0]  zc1r, zc1i, zc2r, zc2i;
  logic [127:0] zc, zout;

  always_comb begin
    bfly_calc(bf_bus.bf_ar, bf_bus.bf_ai, bf_bus.bf_br, bf_bus.bf_bi, bf_bus.bf_wr,
              bf_bus.bf_wi, zc1r, zc1i, zc2r, zc2i);
    zc = {zc1r, zc1i, zc2r, zc2i};
  end

  if (BF_LAT == 1) begin : g_comb
    assign zout = zc;
  end else begin : g_pipe
    logic [127:0] zq [BF_LAT-1];
    always_ff @(posedge clk) begin
      zq[0] <= zc;
      for (int i = 1; i < BF_LAT - 1; i++) zq[i] <= zq[i-1];
    end
    assign zout = zq[BF_LAT-2];
  end

  assign {bf_bus.bf_z1r, bf_bus.bf_z1i, bf_bus.bf_z2r, bf_bus.bf_z2i} = zout;

  always @(negedge clk) begin
    if (bf_bus.bf_valid === 1'b1)
      obs_q.push_back({bf_bus.bf_ar, bf_bus.bf_ai, bf_bus.bf_br, bf_bus.bf_bi,
                       bf_bus.bf_wr, bf_bus.bf_wi});
  end

  // Reference: bit-reversed load, then 3 stages of in-place butterflies.
  task automatic model_fft(input vec_t xr, input vec_t xi, input bit inv_v,
                           output vec_t yr, output vec_t yi);
    vec_t        ar, ai;
    logic [31:0] wr, wi, z1r, z1i, z2r, z2i;
    int          h, g, j, top, bot, k;
    iss_t        e;
    exp_q.delete();
    for (int n = 0; n < 8; n++) begin
      ar[brev(n)] = xr[n];
      ai[brev(n)] = xi[n];
    end
    for (int s = 0; s < 3; s++) begin
      for (int b = 0; b < 4; b++) begin
        h   = 1 << s;
        g   = b >> s;
        j   = b & (h - 1);
        top = g * 2 * h + j;
        bot = top + h;
        k   = j * (4 >> s);
        wr  = tw_re[k];
        wi  = inv_v ? (32'd0 - tw_im[k]) : tw_im[k];
        e   = {ar[top], ai[top], ar[bot], ai[bot], wr, wi};
        exp_q.push_back(e);
        bfly_calc(ar[top], ai[top], ar[bot], ai[bot], wr, wi, z1r, z1i, z2r, z2i);
        ar[top] = z1r;
        ai[top] = z1i;
        ar[bot] = z2r;
        ai[bot] = z2i;
      end
    end
    yr = ar;
    yi = ai;
  endtask

  // Drives a load + transform; returns the done cycle (start edge = cycle 0) or -1.
  task automatic run_fft(input vec_t xr, input vec_t xi, input bit inv_v, input bit disturb,
                         input bit start_in_done, output int done_cyc,
                         output vec_t yr, output vec_t yi, output logic busy_after);
    obs_q.delete();
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = 3'(n);
      ld_re   = xr[n];
      ld_im   = xi[n];
    end
    @(negedge clk);
    ld_we = 1'b0;
    start = 1'b1;
    inv   = inv_v;
    @(negedge clk);
    start    = 1'b0;
    inv      = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 80; c++) begin
      if (done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (disturb && (c == 2 || c == 5 || c == 9 || c == 11)) begin
        start   = 1'b1;
        inv     = ~inv_v;
        ld_we   = 1'b1;
        ld_addr = 3'($urandom_range(0, 7));
        ld_re   = rnd_q();
        ld_im   = rnd_q();
      end else begin
        start = 1'b0;
        ld_we = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    ld_we = 1'b0;
    if (start_in_done && done_cyc > 0) start = 1'b1;
    @(negedge clk);
    busy_after = busy;
    start      = 1'b0;
    for (int n = 0; n < 8; n++) begin
      rd_addr = 3'(n);
      #1;
      yr[n] = rd_re;
      yi[n] = rd_im;
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    inv   = 1'b0;
    ld_we = 1'b0;
    ld_addr = '0;
    ld_re = '0;
    ld_im = '0;
    rd_addr = '0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({busy, done, bf_bus.bf_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags busy/done/bf_valid got %b want 000", {busy, done, bf_bus.bf_valid});
    end
    n_checks++;
    if ({bf_bus.bf_ar, bf_bus.bf_ai, bf_bus.bf_br, bf_bus.bf_bi, bf_bus.bf_wr,
         bf_bus.bf_wi} !== 192'd0) begin
      n_errors++;
      $display("FAIL reset_operands got nonzero want 0 (ar=%h wr=%h)", bf_bus.bf_ar, bf_bus.bf_wr);
    end
    for (int n = 0; n < 8; n++) begin
      rd_addr = 3'(n);
      #1;
      n_checks++;
      if ({rd_re, rd_im} !== 64'd0) begin
        n_errors++;
        $display("FAIL reset_ram[%0d] got %h/%h want 0/0", n, rd_re, rd_im);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_impulse();
    vec_t xr, xi, yr, yi;
    int   dc;
    logic ba;
    for (int n = 0; n < 8; n++) begin
      xr[n] = (n == 0) ? 32'h0001_0000 : 32'h0;
      xi[n] = 32'h0;
    end
    run_fft(xr, xi, 1'b0, 1'b0, 1'b0, dc, yr, yi, ba);
    n_checks++;
    if (dc != DONE_CYC) begin
      n_errors++;
      $display("FAIL impulse_done_cycle got %0d want %0d", dc, DONE_CYC);
    end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (yr[n] !== 32'h0001_0000 || yi[n] !== 32'h0) begin
        n_errors++;
        $display("FAIL impulse_X[%0d] got %h/%h want 00010000/00000000", n, yr[n], yi[n]);
      end
    end
  endtask

  task automatic test_dc();
    vec_t xr, xi, yr, yi;
    int   dc;
    logic ba;
    for (int n = 0; n < 8; n++) begin
      xr[n] = 32'h0001_0000;
      xi[n] = 32'h0;
    end
    run_fft(xr, xi, 1'b0, 1'b0, 1'b0, dc, yr, yi, ba);
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (yr[n] !== ((n == 0) ? 32'h0008_0000 : 32'h0) || yi[n] !== 32'h0) begin
        n_errors++;
        $display("FAIL dc_X[%0d] got %h/%h want %h/00000000", n, yr[n], yi[n],
                 (n == 0) ? 32'h0008_0000 : 32'h0);
      end
    end
  endtask

  task automatic test_round_trip();
    vec_t xr, xi, yr, yi, zr, zi;
    int   dc;
    logic ba;
    for (int n = 0; n < 8; n++) begin
      xr[n] = (n == 0) ? 32'h0001_0000 : 32'h0;
      xi[n] = 32'h0;
    end
    run_fft(xr, xi, 1'b0, 1'b0, 1'b0, dc, yr, yi, ba);
    run_fft(yr, yi, 1'b1, 1'b0, 1'b0, dc, zr, zi, ba);
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (zr[n] !== ((n == 0) ? 32'h0008_0000 : 32'h0) || zi[n] !== 32'h0) begin
        n_errors++;
        $display("FAIL roundtrip_x[%0d] got %h/%h want %h/00000000", n, zr[n], zi[n],
                 (n == 0) ? 32'h0008_0000 : 32'h0);
      end
    end
    n_checks++;
    if (obs_q.size() != 12) begin
      n_errors++;
      $display("FAIL roundtrip_strobes got %0d want 12", obs_q.size());
    end else if (obs_q[10].wi !== 32'h0001_0000) begin
      n_checks++;
      n_errors++;
      $display("FAIL roundtrip_w2_imag got %h want 00010000", obs_q[10].wi);
    end else begin
      n_checks++;
    end
  endtask

  task automatic test_issue_order();
    vec_t xr, xi, yr, yi, er, ei;
    int   dc;
    logic ba;
    bit   iv;
    for (int it = 0; it < 3; it++) begin
      for (int n = 0; n < 8; n++) begin
        xr[n] = rnd_q();
        xi[n] = rnd_q();
      end
      iv = bit'($urandom_range(0, 1));
      model_fft(xr, xi, iv, er, ei);
      run_fft(xr, xi, iv, 1'b0, 1'b0, dc, yr, yi, ba);
      n_checks++;
      if (obs_q.size() != 12) begin
        n_errors++;
        $display("FAIL order_strobes it%0d got %0d want 12", it, obs_q.size());
      end
      for (int i = 0; i < 12 && i < obs_q.size(); i++) begin
        n_checks++;
        if (obs_q[i] !== exp_q[i]) begin
          n_errors++;
          $display("FAIL order_issue it%0d #%0d got %h want %h", it, i, obs_q[i], exp_q[i]);
        end
      end
      for (int n = 0; n < 8; n++) begin
        n_checks++;
        if (yr[n] !== er[n] || yi[n] !== ei[n]) begin
          n_errors++;
          $display("FAIL random_X it%0d [%0d] got %h/%h want %h/%h", it, n, yr[n], yi[n],
                   er[n], ei[n]);
        end
      end
    end
  endtask

  task automatic test_protocol();
    vec_t xr, xi, yr, yi, er, ei;
    int   dc;
    logic ba;
    for (int n = 0; n < 8; n++) begin
      xr[n] = rnd_q();
      xi[n] = rnd_q();
    end
    model_fft(xr, xi, 1'b0, er, ei);
    run_fft(xr, xi, 1'b0, 1'b1, 1'b0, dc, yr, yi, ba);
    n_checks++;
    if (dc != DONE_CYC) begin
      n_errors++;
      $display("FAIL protocol_done_cycle got %0d want %0d", dc, DONE_CYC);
    end
    for (int n = 0; n < 8; n++) begin
      n_checks++;
      if (yr[n] !== er[n] || yi[n] !== ei[n]) begin
        n_errors++;
        $display("FAIL protocol_X[%0d] got %h/%h want %h/%h", n, yr[n], yi[n], er[n], ei[n]);
      end
    end
    // Abort mid-transform with reset during cycle 7.
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      ld_we   = 1'b1;
      ld_addr = 3'(n);
      ld_re   = rnd_q();
      ld_im   = rnd_q();
    end
    @(negedge clk);
    ld_we = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < 7; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if ({busy, done, bf_bus.bf_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL abort_flags busy/done/bf_valid got %b want 000", {busy, done, bf_bus.bf_valid});
    end
    for (int n = 0; n < 8; n++) begin
      rd_addr = 3'(n);
      #1;
      n_checks++;
      if ({rd_re, rd_im} !== 64'd0) begin
        n_errors++;
        $display("FAIL abort_ram[%0d] got %h/%h want 0/0", n, rd_re, rd_im);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t xr, xi, yr, yi, er, ei;
    int   dc;
    logic ba;
    for (int it = 0; it < 2; it++) begin
      for (int n = 0; n < 8; n++) begin
        xr[n] = rnd_q();
        xi[n] = rnd_q();
      end
      model_fft(xr, xi, 1'b1, er, ei);
      run_fft(xr, xi, 1'b1, 1'b0, 1'b1, dc, yr, yi, ba);
      n_checks++;
      if (ba !== 1'b0) begin
        n_errors++;
        $display("FAIL b2b_start_in_done it%0d busy got %b want 0", it, ba);
      end
      for (int n = 0; n < 8; n++) begin
        n_checks++;
        if (yr[n] !== er[n] || yi[n] !== ei[n]) begin
          n_errors++;
          $display("FAIL b2b_X it%0d [%0d] got %h/%h want %h/%h", it, n, yr[n], yi[n],
                   er[n], ei[n]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_round_trip();
    test_issue_order();
    test_protocol();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
